ov7670_capture_param: RTL and testbench

Parametrised OV7670 pixel-capture front end, successor to the fixed 640x480 RGB444 capture block. Sits between the camera pins (pclk domain) and the frame-buffer write port. Pairs bytes into pixels and converts RGB565 or YUV422 luma to a 12-bit pixel. Optionally decimates 2:1 in both axes, and reports frame completion and line-length errors.

---
 rtl/ov7670_cap_pkg.sv | 14 +
 rtl/ov7670_byte_pack.sv | 34 +++
 rtl/ov7670_capture_param.sv | 136 +++++++++++++
 tb/tb_ov7670_capture_param.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_cap_pkg.sv
// Shared types and the byte-pair to 12-bit pixel conversion for the OV7670 capture path.
package ov7670_cap_pkg;

  typedef enum logic {WAIT_FRAME, ACTIVE} cap_state_e;
  typedef enum logic {MODE_RGB565, MODE_YUV_Y} cap_mode_e;

  // YUYV keeps only the luma byte; the chroma byte arrives as b1 and is dropped.
  function automatic logic [11:0] to_pix444(input logic [7:0] b0, input logic [7:0] b1,
                                            input cap_mode_e mode);
    if (mode == MODE_YUV_Y) return {b0[7:4], b0[7:4], b0[7:4]};
    return {b0[7:4], b0[2:0], b1[7], b1[4:1]};
  endfunction

endpackage

// File: rtl/ov7670_byte_pack.sv
// Pairs camera bytes into pixels; pix_valid is high in the cycle the second byte is on d.
module ov7670_byte_pack
  import ov7670_cap_pkg::*;
(
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        href,
  input  logic [7:0]  d,
  input  logic        mode,
  output logic        pix_valid,
  output logic [11:0] pix
);

  logic       phase;
  logic [7:0] b0;

  // Phase realigns on every href low, so a trailing odd byte never pairs with the next line.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      b0    <= '0;
    end else if (en && href) begin
      phase <= ~phase;
      if (!phase) b0 <= d;
    end else begin
      phase <= 1'b0;
    end
  end

  assign pix_valid = en && href && phase;
  assign pix       = to_pix444(b0, d, cap_mode_e'(mode));

endmodule

// File: rtl/ov7670_capture_param.sv
// OV7670 capture front end: frame FSM, decimation, write addressing and frame/line status.
// state      | meaning
// WAIT_FRAME | idle in blanking or after reset; waits for a vsync falling edge
// ACTIVE     | capturing pixels of the current frame until vsync rises
module ov7670_capture_param
  import ov7670_cap_pkg::*;
#(
  parameter int N_COLS = 640,
  parameter int N_ROWS = 480,
  parameter int DECIM  = 1,
  parameter int ADDR_W = $clog2((N_COLS/DECIM)*(N_ROWS/DECIM))
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  input  logic              mode,
  output logic [ADDR_W-1:0] addr,
  output logic [11:0]       pixel,
  output logic              we,
  output logic              frame_done,
  output logic              line_err,
  output logic [7:0]        frame_cnt
);

  localparam int DEPTH  = (N_COLS/DECIM)*(N_ROWS/DECIM);
  localparam int COL_W  = $clog2(N_COLS+2);
  localparam int ROW_W  = $clog2(N_ROWS+2);
  localparam int BYTE_W = $clog2(2*N_COLS+2);
  localparam logic [COL_W-1:0]  COL_END  = COL_W'(N_COLS);
  localparam logic [ROW_W-1:0]  ROW_END  = ROW_W'(N_ROWS);
  localparam logic [ROW_W-1:0]  ROW_SAT  = ROW_W'(N_ROWS+1);
  localparam logic [BYTE_W-1:0] BYTE_END = BYTE_W'(2*N_COLS);
  localparam logic [BYTE_W-1:0] BYTE_SAT = BYTE_W'(2*N_COLS+1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH-1);

  cap_state_e        state;
  cap_mode_e         mode_q;
  logic              vsync_q, href_q;
  logic [ADDR_W-1:0] wr_idx;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [BYTE_W-1:0] byte_cnt;
  logic              pix_valid;
  logic [11:0]       pix;

  ov7670_byte_pack u_pack (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .en        (state == ACTIVE),
    .href      (href),
    .d         (d),
    .mode      (mode_q == MODE_YUV_Y),
    .pix_valid (pix_valid),
    .pix       (pix)
  );

  logic             vs_fall, vs_rise, href_fall, line_bad, err_next, keep, in_window;
  logic [ROW_W-1:0] row_next;

  // Line check and row advance are folded in before the frame-end decision.
  always_comb begin
    vs_fall   = vsync_q & ~vsync;
    vs_rise   = ~vsync_q & vsync;
    href_fall = href_q & ~href;
    line_bad  = href_fall && (byte_cnt != BYTE_END);
    err_next  = line_err | line_bad | (vs_rise & href);
    row_next  = (href_fall && row != ROW_SAT) ? row + 1'b1 : row;
    keep      = (DECIM == 2) ? (~col[0] & ~row[0]) : 1'b1;
    in_window = (col < COL_END) && (row < ROW_END);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_FRAME;
      mode_q     <= MODE_RGB565;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      wr_idx     <= '0;
      col        <= '0;
      row        <= '0;
      byte_cnt   <= '0;
      addr       <= '0;
      pixel      <= '0;
      we         <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      vsync_q    <= vsync;
      href_q     <= href;
      we         <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        WAIT_FRAME: begin
          if (vs_fall) begin
            state    <= ACTIVE;
            mode_q   <= cap_mode_e'(mode);
            wr_idx   <= '0;
            addr     <= '0;
            col      <= '0;
            row      <= '0;
            byte_cnt <= '0;
            line_err <= 1'b0;
          end
        end
        ACTIVE: begin
          if (pix_valid) begin
            if (col != COL_END) col <= col + 1'b1;
            if (in_window && keep) begin
              we    <= 1'b1;
              addr  <= wr_idx;
              pixel <= pix;
              if (wr_idx != IDX_LAST) wr_idx <= wr_idx + 1'b1;
            end
          end
          if (href && byte_cnt != BYTE_SAT) byte_cnt <= byte_cnt + 1'b1;
          if (href_fall) begin
            col      <= '0;
            byte_cnt <= '0;
            row      <= row_next;
          end
          line_err <= err_next;
          if (vs_rise) begin
            frame_done <= 1'b1;
            state      <= WAIT_FRAME;
            if (!err_next && row_next == ROW_END) frame_cnt <= frame_cnt + 1'b1;
          end
        end
        default: state <= WAIT_FRAME;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_capture_param.sv
// Directed bench for ov7670_capture_param: a full-rate and a 2:1 decimating instance on shared camera pins.
module tb_ov7670_capture_param;

  localparam int NC = 8;
  localparam int NR = 6;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b1;
  logic       href = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] d = 8'h00;

  logic [5:0]  addr_a;
  logic [11:0] pixel_a;
  logic        we_a, fd_a, le_a;
  logic [7:0]  fc_a;
  logic [3:0]  addr_b;
  logic [11:0] pixel_b;
  logic        we_b, fd_b, le_b;
  logic [7:0]  fc_b;

  ov7670_capture_param #(.N_COLS(NC), .N_ROWS(NR), .DECIM(1)) u_a (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d), .mode(mode),
    .addr(addr_a), .pixel(pixel_a), .we(we_a), .frame_done(fd_a),
    .line_err(le_a), .frame_cnt(fc_a));

  ov7670_capture_param #(.N_COLS(NC), .N_ROWS(NR), .DECIM(2)) u_b (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d), .mode(mode),
    .addr(addr_b), .pixel(pixel_b), .we(we_b), .frame_done(fd_b),
    .line_err(le_b), .frame_cnt(fc_b));

  always #5 pclk = ~pclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  logic [11:0] exp_pix = 12'h000;
  int cur_row = 0;
  int b1cyc = 0;
  int we_cnt_a = 0, pix_err_a = 0, addr_err_a = 0, fd_cnt_a = 0, first_we_a = -1, last_addr_a = -1;
  int we_cnt_b = 0, pix_err_b = 0, addr_err_b = 0, odd_err_b = 0, sp_err_b = 0, last_we_b = -1, last_addr_b = -1;

  always @(posedge pclk) begin
    #1;
    if (fd_a) fd_cnt_a++;
    if (we_a) begin
      if (we_cnt_a == 0) first_we_a = cyc;
      if (pixel_a !== exp_pix) pix_err_a++;
      if (int'(addr_a) != we_cnt_a) addr_err_a++;
      last_addr_a = int'(addr_a);
      we_cnt_a++;
    end
    if (we_b) begin
      if (pixel_b !== exp_pix) pix_err_b++;
      if (int'(addr_b) != we_cnt_b) addr_err_b++;
      if (cur_row % 2 == 1) odd_err_b++;
      if (last_we_b >= 0 && cyc - last_we_b != 4) sp_err_b++;
      last_we_b = cyc;
      last_addr_b = int'(addr_b);
      we_cnt_b++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic clr();
    we_cnt_a = 0; pix_err_a = 0; addr_err_a = 0; fd_cnt_a = 0; first_we_a = -1; last_addr_a = -1;
    we_cnt_b = 0; pix_err_b = 0; addr_err_b = 0; odd_err_b = 0; sp_err_b = 0; last_we_b = -1; last_addr_b = -1;
  endtask

  // nl lines of 2*NC bytes; short_l gets one byte less; abort_n > 0 cuts the last line with vsync high.
  task automatic frame(input int nl, input int short_l, input int abort_n, input int rst_l,
                       input bit chk_clear, input logic [7:0] x0, input logic [7:0] x1, input logic m);
    int n;
    mode = m; vsync = 1'b1; href = 1'b0; tick(3);
    clr();
    vsync = 1'b0; tick(3);
    if (chk_clear) chk("le_clear_at_start", int'(le_a), 0);
    for (int l = 0; l < nl; l++) begin
      cur_row = l;
      last_we_b = -1;
      n = (l == short_l) ? 2*NC-1 : 2*NC;
      if (abort_n > 0 && l == nl-1) n = abort_n;
      for (int i = 0; i < n; i++) begin
        href = 1'b1;
        d = (i % 2 == 1) ? x1 : x0;
        if (l == 0 && i == 1) b1cyc = cyc + 1;
        if (l == rst_l && i == 5) begin
          rst_n = 1'b0;
          #1;
          chk("midrst_addr", int'(addr_a), 0);
          chk("midrst_we", int'(we_a), 0);
          chk("midrst_pixel", int'(pixel_a), 0);
          chk("midrst_fc", int'(fc_a), 0);
          chk("midrst_le", int'(le_a), 0);
          clr();
        end
        if (l == rst_l && i == 7) rst_n = 1'b1;
        tick(1);
      end
      if (abort_n > 0 && l == nl-1) begin
        vsync = 1'b1;
        tick(1);
      end
      href = 1'b0;
      tick(3);
      if (l == short_l) chk("le_after_short_line", int'(le_a), 1);
    end
    vsync = 1'b1;
    tick(3);
  endtask

  initial begin
    tick(2);
    chk("rst_addr", int'(addr_a), 0);
    chk("rst_pixel", int'(pixel_a), 0);
    chk("rst_we", int'(we_a), 0);
    chk("rst_fd", int'(fd_a), 0);
    chk("rst_le", int'(le_a), 0);
    chk("rst_fc", int'(fc_a), 0);
    rst_n = 1'b1;
    tick(2);

    // clean RGB565 frame
    exp_pix = 12'hF0F;
    frame(NR, -1, 0, -1, 1'b0, 8'hF8, 8'h1F, 1'b0);
    chk("f1_we_a", we_cnt_a, NC*NR);
    chk("f1_pix_a", pix_err_a, 0);
    chk("f1_addr_seq_a", addr_err_a, 0);
    chk("f1_last_addr_a", last_addr_a, NC*NR-1);
    chk("f1_latency_a", first_we_a, b1cyc);
    chk("f1_fd_a", fd_cnt_a, 1);
    chk("f1_fc_a", int'(fc_a), 1);
    chk("f1_le_a", int'(le_a), 0);
    chk("f1_we_b", we_cnt_b, (NC/2)*(NR/2));
    chk("f1_pix_b", pix_err_b, 0);
    chk("f1_addr_seq_b", addr_err_b, 0);
    chk("f1_last_addr_b", last_addr_b, (NC/2)*(NR/2)-1);
    chk("f1_odd_row_b", odd_err_b, 0);
    chk("f1_spacing_b", sp_err_b, 0);
    chk("f1_fc_b", int'(fc_b), 1);

    // YUYV luma frame; chroma byte must not leak in
    exp_pix = 12'hAAA;
    frame(NR, -1, 0, -1, 1'b0, 8'hA5, 8'h80, 1'b1);
    chk("f2_we_a", we_cnt_a, NC*NR);
    chk("f2_pix_a", pix_err_a, 0);
    chk("f2_pix_b", pix_err_b, 0);
    chk("f2_fc_a", int'(fc_a), 2);

    // line 2 one byte short
    exp_pix = 12'hF0F;
    frame(NR, 2, 0, -1, 1'b0, 8'hF8, 8'h1F, 1'b0);
    chk("f3_we_a", we_cnt_a, NC*NR-1);
    chk("f3_fd_a", fd_cnt_a, 1);
    chk("f3_fc_a", int'(fc_a), 2);
    chk("f3_le_held_a", int'(le_a), 1);
    chk("f3_le_b", int'(le_b), 1);

    // two extra lines: no writes past the frame, no frame count
    frame(NR+2, -1, 0, -1, 1'b1, 8'hF8, 8'h1F, 1'b0);
    chk("f4_we_a", we_cnt_a, NC*NR);
    chk("f4_last_addr_a", last_addr_a, NC*NR-1);
    chk("f4_addr_seq_a", addr_err_a, 0);
    chk("f4_le_a", int'(le_a), 0);
    chk("f4_fc_a", int'(fc_a), 2);
    chk("f4_we_b", we_cnt_b, (NC/2)*(NR/2));

    // reset mid line 3: rest of frame ignored
    frame(NR, -1, 0, 3, 1'b0, 8'hF8, 8'h1F, 1'b0);
    chk("f5_we_after_rst_a", we_cnt_a, 0);
    chk("f5_we_after_rst_b", we_cnt_b, 0);
    chk("f5_fd_a", fd_cnt_a, 0);
    chk("f5_fc_a", int'(fc_a), 0);

    // first frame after reset restarts at address 0
    frame(NR, -1, 0, -1, 1'b0, 8'hF8, 8'h1F, 1'b0);
    chk("f6_we_a", we_cnt_a, NC*NR);
    chk("f6_addr_seq_a", addr_err_a, 0);
    chk("f6_fc_a", int'(fc_a), 1);

    // vsync rises while href high on the last line
    frame(NR, -1, 5, -1, 1'b0, 8'hF8, 8'h1F, 1'b0);
    chk("f7_le_a", int'(le_a), 1);
    chk("f7_fd_a", fd_cnt_a, 1);
    chk("f7_fc_a", int'(fc_a), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
